// File: rtl/rv32i_lsu_mem.sv
// RV32I load/store execution stage: one memory op at a time over a req/gnt + rvalid bus,
// returning extended load data or a completion/error status to writeback.
module rv32i_lsu_mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [4:0]  o_rd,
  output logic        o_rd_we,
  output logic [1:0]  o_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        ld_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;

  logic        illegal, misaligned, timeout_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // load && store or neither is illegal; otherwise check f3 against the op
  assign illegal = (i_is_load == i_is_store) ||
                   (i_is_load && (i_f3 == 3'b011 || i_f3[2:1] == 2'b11)) ||
                   (i_is_store && i_f3 >= 3'b011);

  assign misaligned = (i_f3[1:0] == 2'b01 && i_addr[0]) ||
                      (i_f3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);

  // >= so a grant at the last REQ cycle still leaves WAIT bounded
  assign timeout_hit = (cnt >= TO_LAST);

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = i_wdata;
    case (i_f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << i_addr[1:0];
        wdata_n = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << i_addr[1:0];
        wdata_n = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sel = i_mem_rdata[{off_q, 3'b000} +: 8];
  assign half_sel = i_mem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      o_ready     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_be    <= '0;
      o_mem_wdata <= '0;
      o_done      <= 1'b0;
      o_rdata     <= '0;
      o_rd        <= '0;
      o_rd_we     <= 1'b0;
      o_err       <= '0;
      ld_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
    end else begin
      o_done  <= 1'b0;
      o_rdata <= '0;
      o_rd    <= '0;
      o_rd_we <= 1'b0;
      o_err   <= 2'b00;
      unique case (state)
        IDLE: begin
          if (i_valid && o_ready) begin
            ld_q    <= i_is_load;
            f3_q    <= i_f3;
            off_q   <= i_addr[1:0];
            rd_q    <= i_rd;
            o_ready <= 1'b0;
            cnt     <= '0;
            if (illegal || misaligned) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_rd   <= i_rd;
              o_err  <= illegal ? 2'b10 : 2'b01;
            end else begin
              state       <= REQ;
              o_mem_req   <= 1'b1;
              o_mem_we    <= i_is_store;
              o_mem_addr  <= {i_addr[31:2], 2'b00};
              o_mem_be    <= be_n;
              o_mem_wdata <= wdata_n;
            end
          end else begin
            o_ready <= 1'b1;
          end
        end
        REQ: begin
          cnt <= cnt + 16'd1;
          if (i_mem_gnt || timeout_hit) begin
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
          end
          if (i_mem_gnt) begin
            if (ld_q) begin
              state <= WAIT;
            end else begin
              state  <= DONE;
              o_done <= 1'b1;
              o_rd   <= rd_q;
            end
          end else if (timeout_hit) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_rd   <= rd_q;
            o_err  <= 2'b11;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          if (i_mem_rvalid) begin
            state   <= DONE;
            o_done  <= 1'b1;
            o_rd    <= rd_q;
            o_rdata <= load_ext;
            o_rd_we <= (rd_q != 5'd0);
          end else if (timeout_hit) begin
            state  <= DONE;
            o_done <= 1'b1;
            o_rd   <= rd_q;
            o_err  <= 2'b11;
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu_mem.sv
// Scoreboard bench for rv32i_lsu_mem: a bus responder with programmable grant/rvalid
// delays, expected bus beats and completions queued at issue and checked on output.
module tb_rv32i_lsu_mem;

  logic        clk, rst;
  logic        i_valid, o_ready, i_is_load, i_is_store;
  logic [2:0]  i_f3;
  logic [31:0] i_addr, i_wdata;
  logic [4:0]  i_rd;
  logic        o_mem_req, i_mem_gnt, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_done;
  logic [31:0] o_rdata;
  logic [4:0]  o_rd;
  logic        o_rd_we;
  logic [1:0]  o_err;

  rv32i_lsu_mem #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_is_load(i_is_load), .i_is_store(i_is_store),
    .i_f3(i_f3), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd(i_rd),
    .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
    .o_done(o_done), .o_rdata(o_rdata), .o_rd(o_rd), .o_rd_we(o_rd_we), .o_err(o_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rd_we;
    logic [1:0]  err;
    int          cyc;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  done_t dq[$];
  bus_t  bq[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cycles = 0;
  int gnt_wait = 0;
  int rv_wait = 1;
  logic [31:0] rd_word = '0;
  logic inject_rv = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // completion monitor
  initial forever begin
    done_t e;
    @(negedge clk);
    if (!rst) begin
      if (o_done) begin
        if (dq.size() == 0) chk("unexp_done", 32'(o_done), 32'd0);
        else begin
          e = dq.pop_front();
          chk("rdata", o_rdata, e.rdata);
          chk("rd", 32'(o_rd), 32'(e.rd));
          chk("rd_we", 32'(o_rd_we), 32'(e.rd_we));
          chk("err", 32'(o_err), 32'(e.err));
          chk("done_cyc", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        chk("quiet", 32'({o_rd_we, o_err}), 32'd0);
      end
    end
  end

  // bus responder
  initial begin
    int rq, rvc;
    bit pend;
    bus_t b;
    rq = 0; rvc = 0; pend = 1'b0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_gnt = 1'b0;
      i_mem_rvalid = 1'b0;
      if (rst || o_done) begin pend = 1'b0; rq = 0; end
      if (pend) begin
        rvc++;
        if (rvc == rv_wait) begin
          i_mem_rvalid = 1'b1;
          i_mem_rdata = rd_word;
          pend = 1'b0;
        end
      end
      if (inject_rv) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
      end
      if (o_mem_req && !rst) begin
        req_cycles++;
        if (rq == gnt_wait) begin
          i_mem_gnt = 1'b1;
          rq = 0;
          if (bq.size() == 0) chk("unexp_gnt", 32'd1, 32'd0);
          else begin
            b = bq.pop_front();
            chk("bus_addr", o_mem_addr, b.addr);
            chk("bus_be", 32'(o_mem_be), 32'(b.be));
            chk("bus_we", 32'(o_mem_we), 32'(b.we));
            if (b.we) chk("bus_wdata", o_mem_wdata, b.wdata);
          end
          if (!o_mem_we) begin pend = 1'b1; rvc = 0; end
        end else rq++;
      end else rq = 0;
    end
  end

  // caller is at a negedge; expected values are all supplied by the caller
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input int lat, input logic [1:0] err, input logic [31:0] rdata,
                       input logic rd_we, input int nreq, input bit bus,
                       input logic [3:0] be, input logic [31:0] bwd, input bit wait_done);
    int n, r0;
    n = 0;
    while (!o_ready && n < 50) begin @(negedge clk); n++; end
    if (!o_ready) begin chk("ready_timeout", 32'(o_ready), 32'd1); return; end
    i_valid = 1'b1; i_is_load = ld; i_is_store = st;
    i_f3 = f3; i_addr = addr; i_wdata = wd; i_rd = rd;
    dq.push_back('{rdata, rd, rd_we, err, cyc + lat});
    if (bus) bq.push_back('{{addr[31:2], 2'b00}, be, bwd, st});
    r0 = req_cycles;
    @(negedge clk);
    i_valid = 1'b0;
    if (wait_done) begin
      n = 0;
      while (dq.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (dq.size() != 0) begin chk("done_timeout", 32'd0, 32'd1); dq.delete(); end
      @(negedge clk);
      chk("req_cycles", 32'(req_cycles - r0), 32'(nreq));
    end
  endtask

  task automatic pulse_rv();
    @(posedge clk); #1 inject_rv = 1'b1;
    @(posedge clk); #1 inject_rv = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_is_load = 1'b0; i_is_store = 1'b0;
    i_f3 = '0; i_addr = '0; i_wdata = '0; i_rd = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_bus", o_mem_addr | o_mem_wdata | 32'(o_mem_be), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    gnt_wait = 0; rv_wait = 1;
    // SB to byte 3, immediate grant
    issue(0, 1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd0, 2, 2'b00, 32'h0, 0, 1, 1, 4'b1000, 32'hABAB_ABAB, 1);
    rd_word = 32'h0080_FF00;
    issue(1, 0, 3'b000, 32'h2002, 32'h0, 5'd5, 3, 2'b00, 32'hFFFF_FF80, 1, 1, 1, 4'b0100, 32'h0, 1);
    issue(1, 0, 3'b100, 32'h2002, 32'h0, 5'd5, 3, 2'b00, 32'h0000_0080, 1, 1, 1, 4'b0100, 32'h0, 1);
    rd_word = 32'h8001_1234;
    issue(1, 0, 3'b001, 32'h2002, 32'h0, 5'd7, 3, 2'b00, 32'hFFFF_8001, 1, 1, 1, 4'b1100, 32'h0, 1);
    issue(1, 0, 3'b101, 32'h2000, 32'h0, 5'd7, 3, 2'b00, 32'h0000_1234, 1, 1, 1, 4'b0011, 32'h0, 1);
    // errors: no bus activity, done one cycle after accept
    issue(1, 0, 3'b010, 32'h2001, 32'h0, 5'd6, 1, 2'b01, 32'h0, 0, 0, 0, 4'b0, 32'h0, 1);
    issue(1, 0, 3'b011, 32'h2000, 32'h0, 5'd6, 1, 2'b10, 32'h0, 0, 0, 0, 4'b0, 32'h0, 1);
    issue(1, 1, 3'b010, 32'h2000, 32'h0, 5'd6, 1, 2'b10, 32'h0, 0, 0, 0, 4'b0, 32'h0, 1);
    issue(0, 1, 3'b011, 32'h2000, 32'h0, 5'd6, 1, 2'b10, 32'h0, 0, 0, 0, 4'b0, 32'h0, 1);
    issue(0, 1, 3'b001, 32'h2003, 32'h0, 5'd6, 1, 2'b01, 32'h0, 0, 0, 0, 4'b0, 32'h0, 1);
    // LW rd=0 never writes the register file
    rd_word = 32'h1234_5678;
    issue(1, 0, 3'b010, 32'h3000, 32'h0, 5'd0, 3, 2'b00, 32'h1234_5678, 0, 1, 1, 4'b1111, 32'h0, 1);
    // delayed grants
    gnt_wait = 1;
    issue(0, 1, 3'b001, 32'h1002, 32'h1234_ABCD, 5'd2, 3, 2'b00, 32'h0, 0, 2, 1, 4'b1100, 32'hABCD_ABCD, 1);
    gnt_wait = 0;
    issue(0, 1, 3'b010, 32'h1004, 32'hCAFE_F00D, 5'd2, 2, 2'b00, 32'h0, 0, 1, 1, 4'b1111, 32'hCAFE_F00D, 1);
    // timeout in REQ: four request cycles, then err 11
    gnt_wait = 100;
    issue(0, 1, 3'b010, 32'h1008, 32'h1111_2222, 5'd8, 5, 2'b11, 32'h0, 0, 4, 0, 4'b1111, 32'h0, 1);
    // grant on the last allowed cycle wins
    gnt_wait = 3;
    issue(0, 1, 3'b010, 32'h100C, 32'h3333_4444, 5'd8, 5, 2'b00, 32'h0, 0, 4, 1, 4'b1111, 32'h3333_4444, 1);
    // rvalid on the last allowed cycle wins
    gnt_wait = 1; rv_wait = 2; rd_word = 32'h0000_7FFF;
    issue(1, 0, 3'b001, 32'h5000, 32'h0, 5'd9, 5, 2'b00, 32'h0000_7FFF, 1, 2, 1, 4'b0011, 32'h0, 1);
    // timeout in WAIT, then a stray rvalid in IDLE must be ignored
    gnt_wait = 0; rv_wait = 5;
    issue(1, 0, 3'b010, 32'h4000, 32'h0, 5'd3, 5, 2'b11, 32'h0, 0, 1, 1, 4'b1111, 32'h0, 1);
    pulse_rv();

    // reset while in WAIT abandons the load
    rv_wait = 100;
    issue(1, 0, 3'b010, 32'h6000, 32'h0, 5'd4, 3, 2'b00, 32'h0, 1, 1, 1, 4'b1111, 32'h0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dq.delete();
    chk("wrst_req", 32'(o_mem_req), 32'd0);
    chk("wrst_done", 32'(o_done), 32'd0);
    chk("wrst_ready", 32'(o_ready), 32'd0);
    rst = 1'b0;
    pulse_rv();
    rv_wait = 1; rd_word = 32'h89AB_CDEF;
    issue(1, 0, 3'b010, 32'h6004, 32'h0, 5'd4, 3, 2'b00, 32'h89AB_CDEF, 1, 1, 1, 4'b1111, 32'h0, 1);

    repeat (2) @(negedge clk);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("bq_empty", 32'(bq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
